// File: rtl/cube_match_pkg.sv
// rtl/cube_match_pkg.sv - shared defaults and index-width helper for the cube matcher
package cube_match_pkg;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_NCUBES    = 4;
    localparam int DEF_HOLD_BITS = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cube_match_seq_if.sv
// rtl/cube_match_seq_if.sv - sample, config and result bundle of cube_match_seq
interface cube_match_seq_if
    import cube_match_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NCUBES    = DEF_NCUBES,
    parameter int HOLD_BITS = DEF_HOLD_BITS
);
    localparam int IDX_W = idx_w(NCUBES);

    logic                 in_valid;
    logic [WIDTH-1:0]     in_data;
    logic                 cfg_we;
    logic [IDX_W-1:0]     cfg_idx;
    logic [WIDTH-1:0]     cfg_value;
    logic [WIDTH-1:0]     cfg_care;
    logic                 cfg_en;
    logic [HOLD_BITS-1:0] cfg_hold;
    logic                 sticky_clr;
    logic [NCUBES-1:0]    hit;
    logic                 any_hit;
    logic                 first_vld;
    logic [IDX_W-1:0]     first_idx;
    logic [NCUBES-1:0]    sticky;

    modport master (
        output in_valid, in_data, cfg_we, cfg_idx, cfg_value, cfg_care, cfg_en,
               cfg_hold, sticky_clr,
        input  hit, any_hit, first_vld, first_idx, sticky
    );

    modport slave (
        input  in_valid, in_data, cfg_we, cfg_idx, cfg_value, cfg_care, cfg_en,
               cfg_hold, sticky_clr,
        output hit, any_hit, first_vld, first_idx, sticky
    );

endinterface

// File: rtl/cube_match_lane.sv
// rtl/cube_match_lane.sv - one cube: config regs, comparator, run counter, hit and sticky flops
module cube_match_lane #(
    parameter int WIDTH     = 16,
    parameter int HOLD_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_wr,
    input  logic [WIDTH-1:0]     cfg_value,
    input  logic [WIDTH-1:0]     cfg_care,
    input  logic                 cfg_en,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 valid_s1,
    input  logic [HOLD_BITS-1:0] hold_eff,
    input  logic                 sticky_clr,
    output logic                 hit_nxt,
    output logic                 hit,
    output logic                 sticky
);
    typedef struct packed {
        logic [WIDTH-1:0] value;
        logic [WIDTH-1:0] care;
        logic             en;
    } cube_cfg_t;

    localparam logic [HOLD_BITS-1:0] CNT_MAX = '1;

    cube_cfg_t            cfg_q;
    logic                 match_raw;
    logic                 match_s1;
    logic [HOLD_BITS-1:0] cnt;
    logic [HOLD_BITS-1:0] cnt_nxt;

    assign match_raw = cfg_q.en & ~|((in_data ^ cfg_q.value) & cfg_q.care);

    // Bubbles hold the run; the counter saturates instead of wrapping.
    always_comb begin
        cnt_nxt = cnt;
        if (valid_s1) begin
            if (!match_s1)
                cnt_nxt = '0;
            else if (cnt != CNT_MAX)
                cnt_nxt = cnt + HOLD_BITS'(1);
        end
        hit_nxt = cfg_q.en & valid_s1 & match_s1 & (cnt_nxt >= hold_eff);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q    <= '0;
            match_s1 <= 1'b0;
            cnt      <= '0;
            hit      <= 1'b0;
            sticky   <= 1'b0;
        end else begin
            if (cfg_wr)
                cfg_q <= '{value: cfg_value, care: cfg_care, en: cfg_en};
            match_s1 <= match_raw;
            // A rewrite restarts the run; the in-flight sample still finishes on the old cube.
            cnt      <= cfg_wr ? '0 : cnt_nxt;
            hit      <= hit_nxt;
            sticky   <= hit | (sticky & ~sticky_clr);
        end
    end

endmodule

// File: rtl/cube_match_seq.sv
// rtl/cube_match_seq.sv - pipelined multi-cube pattern detector with run qualification
module cube_match_seq
    import cube_match_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NCUBES    = DEF_NCUBES,
    parameter int HOLD_BITS = DEF_HOLD_BITS
) (
    input  logic             clk,
    input  logic             rst,
    cube_match_seq_if.slave  bus
);
    localparam int IDX_W = idx_w(NCUBES);

    logic                 valid_s1;
    logic [HOLD_BITS-1:0] hold_eff;
    logic [NCUBES-1:0]    hit_nxt;
    logic [NCUBES-1:0]    hit_q;
    logic [NCUBES-1:0]    sticky_q;
    logic                 any_q;
    logic [IDX_W-1:0]     first_nxt;
    logic [IDX_W-1:0]     first_q;

    assign hold_eff = (bus.cfg_hold == '0) ? HOLD_BITS'(1) : bus.cfg_hold;

    generate
        for (genvar c = 0; c < NCUBES; c++) begin : g_lane
            logic cfg_wr;
            assign cfg_wr = bus.cfg_we && (bus.cfg_idx == IDX_W'(c));

            cube_match_lane #(
                .WIDTH     (WIDTH),
                .HOLD_BITS (HOLD_BITS)
            ) u_lane (
                .clk        (clk),
                .rst        (rst),
                .cfg_wr     (cfg_wr),
                .cfg_value  (bus.cfg_value),
                .cfg_care   (bus.cfg_care),
                .cfg_en     (bus.cfg_en),
                .in_data    (bus.in_data),
                .valid_s1   (valid_s1),
                .hold_eff   (hold_eff),
                .sticky_clr (bus.sticky_clr),
                .hit_nxt    (hit_nxt[c]),
                .hit        (hit_q[c]),
                .sticky     (sticky_q[c])
            );
        end
    endgenerate

    // Scan downward so the lowest set index is the one left standing.
    always_comb begin
        first_nxt = '0;
        for (int i = NCUBES - 1; i >= 0; i--) begin
            if (hit_nxt[i])
                first_nxt = IDX_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_s1 <= 1'b0;
            any_q    <= 1'b0;
            first_q  <= '0;
        end else begin
            valid_s1 <= bus.in_valid;
            any_q    <= |hit_nxt;
            first_q  <= first_nxt;
        end
    end

    assign bus.hit       = hit_q;
    assign bus.any_hit   = any_q;
    assign bus.first_vld = any_q;
    assign bus.first_idx = first_q;
    assign bus.sticky    = sticky_q;

endmodule

// File: tb/tb_cube_match_seq.sv
// tb/tb_cube_match_seq.sv - directed self-checking bench for cube_match_seq
module tb_cube_match_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    cube_match_seq_if #(.WIDTH(16), .NCUBES(4), .HOLD_BITS(2)) bus ();

    cube_match_seq #(.WIDTH(16), .NCUBES(4), .HOLD_BITS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d);
        bus.in_valid = v;
        bus.in_data  = d;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [15:0] val,
                             input logic [15:0] care, input logic en);
        bus.cfg_we    = 1'b1;
        bus.cfg_idx   = idx;
        bus.cfg_value = val;
        bus.cfg_care  = care;
        bus.cfg_en    = en;
        tick();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_hit"}, 32'(bus.hit), 0);
        chk({tag, "_any"}, 32'(bus.any_hit), 0);
        chk({tag, "_fvld"}, 32'(bus.first_vld), 0);
        chk({tag, "_fidx"}, 32'(bus.first_idx), 0);
        chk({tag, "_sticky"}, 32'(bus.sticky), 0);
    endtask

    logic        rv [6];
    logic [15:0] rd [6];
    logic        rexp [6];

    initial begin
        drive(1'b0, 16'h0);
        bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_value = '0; bus.cfg_care = '0;
        bus.cfg_en = 1'b0; bus.cfg_hold = 2'd1; bus.sticky_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_all_zero("reset");

        // basic single match
        cfg_write(2'd0, 16'h1234, 16'hFFFF, 1'b1);
        drive(1'b1, 16'h1234); tick();
        drive(1'b0, 16'h0000);
        chk("basic_t1_hit", 32'(bus.hit), 0);
        tick();
        chk("basic_hit", 32'(bus.hit), 32'h1);
        chk("basic_any", 32'(bus.any_hit), 1);
        chk("basic_fvld", 32'(bus.first_vld), 1);
        chk("basic_fidx", 32'(bus.first_idx), 0);
        chk("basic_sticky_t2", 32'(bus.sticky), 0);
        tick();
        chk("basic_hit_t3", 32'(bus.hit), 0);
        chk("basic_sticky_t3", 32'(bus.sticky), 32'h1);
        bus.sticky_clr = 1'b1; tick(); bus.sticky_clr = 1'b0;
        chk("sticky_clr", 32'(bus.sticky), 0);

        // don't-care bits and lowest-index priority
        cfg_write(2'd1, 16'h0034, 16'h00FF, 1'b1);
        cfg_write(2'd3, 16'h0000, 16'h0000, 1'b1);
        drive(1'b1, 16'hAB34); tick();
        drive(1'b1, 16'hAB35); tick();
        drive(1'b0, 16'h0000);
        chk("dc_hit_ab34", 32'(bus.hit), 32'hA);
        chk("dc_fidx_ab34", 32'(bus.first_idx), 1);
        tick();
        chk("dc_hit_ab35", 32'(bus.hit), 32'h8);
        chk("dc_fidx_ab35", 32'(bus.first_idx), 3);
        tick();
        chk("dc_hit_idle", 32'(bus.hit), 0);
        chk("dc_any_idle", 32'(bus.any_hit), 0);
        cfg_write(2'd1, 16'h0034, 16'h00FF, 1'b0);
        cfg_write(2'd3, 16'h0000, 16'h0000, 1'b0);
        bus.sticky_clr = 1'b1; tick(); bus.sticky_clr = 1'b0;

        // run qualification across a bubble, broken by a mismatch
        bus.cfg_hold = 2'd3;
        rv = '{1, 0, 1, 1, 1, 1};
        rd = '{16'h1234, 16'h0000, 16'h1234, 16'h1234, 16'h0000, 16'h1234};
        rexp = '{0, 0, 0, 1, 0, 0};
        for (int k = 0; k < 8; k++) begin
            if (k < 6) drive(rv[k], rd[k]); else drive(1'b0, 16'h0000);
            tick();
            chk($sformatf("run_k%0d", k), 32'(bus.hit),
                (k >= 1 && k <= 6) ? 32'(rexp[k-1]) : 32'h0);
        end

        // saturation: 2-bit counter, threshold 3, ten matches
        cfg_write(2'd0, 16'h1234, 16'hFFFF, 1'b1);
        for (int k = 0; k < 12; k++) begin
            drive(k < 10, 16'h1234);
            tick();
            chk($sformatf("sat_k%0d", k), 32'(bus.hit),
                (k - 1 >= 2 && k - 1 <= 9) ? 32'h1 : 32'h0);
        end

        // reconfiguration with a run in flight
        bus.cfg_hold = 2'd2;
        drive(1'b1, 16'h0000); tick();
        drive(1'b1, 16'h1234); tick();
        drive(1'b1, 16'h1234); tick();
        drive(1'b0, 16'h0000);
        cfg_write(2'd0, 16'h5555, 16'hFFFF, 1'b1);
        rv = '{1, 1, 1, 0, 0, 0};
        rd = '{16'h5555, 16'h5555, 16'h1234, 16'h0000, 16'h0000, 16'h0000};
        rexp = '{0, 1, 0, 0, 0, 0};
        for (int k = 0; k < 5; k++) begin
            drive(rv[k], rd[k]);
            tick();
            chk($sformatf("recfg_k%0d", k), 32'(bus.hit),
                (k >= 1) ? 32'(rexp[k-1]) : 32'h0);
        end

        // reset mid-run clears everything including enables
        bus.cfg_hold = 2'd3;
        chk("pre_rst_sticky", 32'(bus.sticky), 32'h1);
        drive(1'b1, 16'h5555); tick();
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        drive(1'b0, 16'h0000);
        check_all_zero("midrst");
        bus.cfg_hold = 2'd1;
        for (int k = 0; k < 5; k++) begin
            drive(k < 3, 16'h5555);
            tick();
            chk($sformatf("en_off_k%0d", k), 32'(bus.hit), 0);
        end

        // sticky set wins over a simultaneous clear
        cfg_write(2'd0, 16'h5555, 16'hFFFF, 1'b1);
        drive(1'b1, 16'h5555); tick();
        drive(1'b0, 16'h0000); tick();
        chk("sc_hit", 32'(bus.hit), 32'h1);
        bus.sticky_clr = 1'b1; tick();
        chk("sc_set_wins", 32'(bus.sticky), 32'h1);
        tick(); bus.sticky_clr = 1'b0;
        chk("sc_cleared", 32'(bus.sticky), 0);

        // threshold 0 behaves as 1
        bus.cfg_hold = 2'd0;
        drive(1'b1, 16'h0000); tick();
        drive(1'b1, 16'h5555); tick();
        drive(1'b0, 16'h0000); tick();
        chk("hold0_hit", 32'(bus.hit), 32'h1);
        chk("hold0_fidx", 32'(bus.first_idx), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
